// File: rtl/cell_line_fetch.sv
// Prefetches one display line of cell states from the cell RAM into a ping-pong line buffer
// and serialises the front buffer into a per-pixel cell_on bit.
module cell_line_fetch #(
    parameter int unsigned CELL_PX        = 4,
    parameter int unsigned CELLS_PER_WORD = 20,
    parameter int unsigned WORDS_PER_ROW  = 16,
    parameter int unsigned NUM_ROWS       = 256,
    parameter int unsigned RAM_LAT        = 2,
    parameter int unsigned BASE_ADDR      = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      line_req,
    input  logic [10:0]               line_num,
    input  logic                      active,
    output logic [15:0]               address_b_1,
    output logic                      read1,
    input  logic [CELLS_PER_WORD-1:0] q_b_1,
    output logic                      cell_on,
    output logic                      fetch_busy,
    output logic                      underrun
);

    localparam int unsigned ShiftAmt = $clog2(CELL_PX);
    localparam int unsigned SubW     = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam int unsigned BitW     = (CELLS_PER_WORD > 1) ? $clog2(CELLS_PER_WORD) : 1;
    localparam int unsigned WordW    = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                    state;
    logic [WordW-1:0]          issue_idx;
    logic [RAM_LAT-1:0]        tag_vld;
    logic [WordW-1:0]          tag_idx [RAM_LAT];
    logic [CELLS_PER_WORD-1:0] back    [WORDS_PER_ROW];
    logic [CELLS_PER_WORD-1:0] front   [WORDS_PER_ROW];
    logic                      back_valid;

    logic [15:0]      row_base;
    logic             in_range;
    logic             tag_out_vld;
    logic [WordW-1:0] tag_out_idx;

    assign row_base    = 16'(BASE_ADDR + ((32'(line_num) >> ShiftAmt) * WORDS_PER_ROW));
    assign in_range    = 32'(line_num) < (NUM_ROWS * CELL_PX);
    assign tag_out_vld = tag_vld[RAM_LAT-1];
    assign tag_out_idx = tag_idx[RAM_LAT-1];
    assign fetch_busy  = (state != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            read1       <= 1'b0;
            address_b_1 <= '0;
            issue_idx   <= '0;
            tag_vld     <= '0;
            back_valid  <= 1'b0;
            underrun    <= 1'b0;
            for (int k = 0; k < RAM_LAT; k++) tag_idx[k] <= '0;
            for (int k = 0; k < WORDS_PER_ROW; k++) begin
                back[k]  <= '0;
                front[k] <= '0;
            end
        end else begin
            // Tag pipeline tracks which buffer slot each in-flight read belongs to.
            tag_vld[0] <= read1;
            tag_idx[0] <= issue_idx;
            for (int k = 1; k < RAM_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
            if (tag_out_vld && !line_req) back[tag_out_idx] <= q_b_1;

            case (state)
                StIssue: begin
                    if (issue_idx == WordW'(WORDS_PER_ROW - 1)) begin
                        state <= StDrain;
                        read1 <= 1'b0;
                    end else begin
                        issue_idx   <= issue_idx + 1'b1;
                        address_b_1 <= address_b_1 + 16'd1;
                    end
                end
                StDrain: begin
                    if (tag_out_vld && tag_out_idx == WordW'(WORDS_PER_ROW - 1)) begin
                        back_valid <= 1'b1;
                        state      <= StIdle;
                    end
                end
                default: ;
            endcase

            // A new line request overrides everything: swap, abort, restart.
            if (line_req) begin
                for (int k = 0; k < WORDS_PER_ROW; k++) begin
                    front[k] <= back_valid ? back[k] : '0;
                end
                if (!back_valid || state != StIdle) underrun <= 1'b1;
                back_valid <= 1'b0;
                tag_vld    <= '0;
                if (in_range) begin
                    state       <= StIssue;
                    read1       <= 1'b1;
                    address_b_1 <= row_base;
                    issue_idx   <= '0;
                end else begin
                    for (int k = 0; k < WORDS_PER_ROW; k++) back[k] <= '0;
                    back_valid <= 1'b1;
                    state      <= StIdle;
                    read1      <= 1'b0;
                end
            end
        end
    end

    logic             active_q;
    logic [SubW-1:0]  sub_q, cur_sub;
    logic [BitW-1:0]  bit_q, cur_bit;
    logic [WordW-1:0] word_q, cur_word;

    always_comb begin
        cur_sub  = sub_q;
        cur_bit  = bit_q;
        cur_word = word_q;
        if (active && !active_q) begin
            cur_sub  = '0;
            cur_bit  = '0;
            cur_word = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            sub_q    <= '0;
            bit_q    <= '0;
            word_q   <= '0;
            cell_on  <= 1'b0;
        end else begin
            active_q <= active;
            if (active) begin
                cell_on <= front[cur_word][cur_bit];
                if (cur_sub == SubW'(CELL_PX - 1)) begin
                    sub_q <= '0;
                    if (cur_bit == BitW'(CELLS_PER_WORD - 1)) begin
                        bit_q <= '0;
                        // Word index saturates on the last word of the row.
                        word_q <= (cur_word == WordW'(WORDS_PER_ROW - 1)) ? cur_word
                                                                        : cur_word + 1'b1;
                    end else begin
                        bit_q  <= cur_bit + 1'b1;
                        word_q <= cur_word;
                    end
                end else begin
                    sub_q  <= cur_sub + 1'b1;
                    bit_q  <= cur_bit;
                    word_q <= cur_word;
                end
            end else begin
                cell_on <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cell_line_fetch.md
Name: cell_line_fetch

Overview:
- Upstream stage of the VGA_LED display path. Reads cell-state words from port B of the cell RAM and stores one display line of cells in a ping-pong line buffer.
- While the VGA timing scans that line, the block serialises the buffer into a per-pixel cell_on bit.
- Each cell covers CELL_PX x CELL_PX pixels. Each 20-bit RAM word holds CELLS_PER_WORD cells; word bit 0 is the leftmost cell.

Parameters:
- CELL_PX, 4, pixels per cell edge; power of two.
- CELLS_PER_WORD, 20, cells per RAM word; equals the q_b_1 width.
- WORDS_PER_ROW, 16, RAM words per cell row (16 x 20 = 320 cells = 1280 px).
- NUM_ROWS, 256, cell rows (256 x 4 = 1024 lines).
- RAM_LAT, 2, cycles from address_b_1/read1 to valid q_b_1.
- BASE_ADDR, 0, RAM word address of cell row 0, word 0.

Ports:
- clk  in  1  pixel clock (108 MHz).
- reset  in  1  synchronous, active-high.
- line_req  in  1  one-cycle pulse from VGA timing at the start of each line's horizontal blank.
- line_num  in  11  display line to prefetch; sampled when line_req=1.
- active  in  1  high during visible pixels of the current line.
- address_b_1  out  16  RAM port-B word address.
- read1  out  1  RAM read strobe; one read per cycle when high.
- q_b_1  in  20  RAM read data, valid RAM_LAT cycles after its read1.
- cell_on  out  1  cell state for the current pixel, registered.
- fetch_busy  out  1  high while a line fetch is in progress.
- underrun  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values:
  - address_b_1=0, read1=0, cell_on=0, fetch_busy=0, underrun=0.
  - Both buffers zeroed; back_valid=0; FSM=IDLE.
  - Any in-flight read tags are discarded.
- FSM states: IDLE, ISSUE, DRAIN.
- On line_req, in any state, all of the following occur in the same cycle:
  - Swap: front takes back's contents if back_valid=1; otherwise front is cleared to zeros and underrun is set. back_valid is then cleared.
  - If the FSM is in ISSUE or DRAIN: underrun is set, outstanding read tags are killed (late q_b_1 is ignored), and the fetch restarts.
  - row = line_num >> log2(CELL_PX).
  - If line_num >= NUM_ROWS*CELL_PX: back is cleared, back_valid=1, FSM goes to IDLE, and no reads are issued.
  - Otherwise: FSM goes to ISSUE with issue counter i=0.
- ISSUE state:
  - Each cycle drives read1=1 and address_b_1 = BASE_ADDR + row*WORDS_PER_ROW + i (truncated to 16 bits), then increments i.
  - After i = WORDS_PER_ROW-1 is issued, the FSM goes to DRAIN.
  - Each read pushes its word index into a RAM_LAT-deep tag pipeline.
  - When a tag exits the pipeline, q_b_1 is written to back[tag].
- DRAIN state:
  - read1=0.
  - When the last tag has been written, back_valid=1 and the FSM goes to IDLE.
  - Total fetch time: WORDS_PER_ROW + RAM_LAT cycles after the line_req cycle.
- fetch_busy = (state != IDLE).
- Pixel serialiser (independent of the FSM):
  - On the first active cycle of a line (active rising), sub=0, bit=0, word=0.
  - On each active cycle, sub increments. When sub wraps at CELL_PX, bit increments. When bit wraps at CELLS_PER_WORD, word increments. word saturates at WORDS_PER_ROW-1; it does not wrap.
  - cell_on(t+1) = active(t) ? front[word][bit] : 0. Latency is one cycle, so the timing block delays RGB by one cycle.
- A swap never happens while active=1, because line_req occurs only in blank. If line_req and active are both high, the swap still occurs and the serialiser continues with the new front buffer.

Test Plan:
- Reset: hold reset 3 cycles while line_req pulses -> all outputs 0, no read1, cell_on=0 during active.
- Fetch sequence: line_req with line_num=8 (row 2), BASE_ADDR=0 -> read1 high for exactly 16 cycles, addresses 32..47 consecutive; fetch_busy high for 18 cycles; back_valid set.
- Pixel output: RAM word 32 = 20'h00001, others 0; fetch line 8; next line_req swaps; hold active 1280 cycles -> cell_on=1 for the first 4 pixels, 0 for the remaining 1276, each one cycle after active.
- Underrun: line_req, then a second line_req after 5 cycles -> underrun=1, front zeroed, addresses restart at the new row's word 0; late q_b_1 from the aborted reads is not written.
- Out of range: line_num=1030 -> no read1 pulses, fetch_busy stays 0; after the next swap, cell_on=0 for the whole line.
- Last word: word 47 = 20'h80000 -> cell_on=1 only for pixels 1276..1279.
